// File: rtl/axis_packetizer.sv
// axis_packetizer: AXI-Stream pass-through that imposes packet boundaries.
// Each packet ends after packet_beats beats or at an input tlast, whichever
// comes first. The output is fully registered through a main/skid buffer pair.
`timescale 1ns/1ps
module axis_packetizer #(
    parameter int BUS_WIDTH   = 1,
    parameter int USER_WIDTH  = 1,
    parameter int DEST_WIDTH  = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [BUS_WIDTH*8-1:0]   s_axis_tdata,
    input  logic [BUS_WIDTH-1:0]     s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [BUS_WIDTH*8-1:0]   m_axis_tdata,
    output logic [BUS_WIDTH-1:0]     m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    output logic [DEST_WIDTH-1:0]    m_axis_tdest,
    input  logic [COUNT_WIDTH-1:0]   packet_beats,
    output logic                     early_last
);

    localparam int BEAT_W = BUS_WIDTH * 8 + BUS_WIDTH + 1 + USER_WIDTH + DEST_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [COUNT_WIDTH-1:0]  count_reg;
    logic [COUNT_WIDTH-1:0]  size_reg;
    logic                    early_reg;

    logic [BEAT_W-1:0]       main_reg, main_next;
    logic [BEAT_W-1:0]       skid_reg, skid_next;
    logic                    main_valid_reg, main_valid_next;
    logic                    skid_valid_reg, skid_valid_next;
    logic                    tready_reg;

    logic                    accept;
    logic [COUNT_WIDTH-1:0]  size_eff;
    logic                    size_nz;
    logic                    beat_last;
    logic                    short_last;
    logic [BEAT_W-1:0]       in_beat;

    assign accept  = s_axis_tvalid & tready_reg;
    assign in_beat = {s_axis_tdata, s_axis_tkeep, beat_last, s_axis_tuser, s_axis_tdest};

    // FSM state register
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM next state: a non-last accepted beat opens a packet, a last beat closes it
    always_comb begin
        state_next = state_reg;
        if (accept) state_next = beat_last ? IDLE : ACTIVE;
    end

    // FSM outputs: effective size (live value on the first beat) and last-beat decode
    always_comb begin
        size_eff   = (state_reg == IDLE) ? packet_beats : size_reg;
        size_nz    = (size_eff != '0);
        beat_last  = s_axis_tlast | (size_nz && (count_reg == size_eff - ONE));
        short_last = s_axis_tlast && size_nz && (count_reg < size_eff - ONE);
    end

    // Beat counter, latched packet size and early-termination pulse
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            count_reg <= '0;
            size_reg  <= '0;
            early_reg <= 1'b0;
        end else begin
            early_reg <= accept & short_last;
            if (accept) begin
                if (state_reg == IDLE) size_reg <= packet_beats;
                count_reg <= beat_last ? '0 : count_reg + ONE;
            end else if (state_reg == IDLE) begin
                count_reg <= '0;
            end
        end
    end

    // Skid buffer steering: main drains from skid first, skid only catches a beat
    // accepted while main is blocked
    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (!main_valid_reg || m_axis_tready) begin
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_next       = in_beat;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next       = in_beat;
            skid_valid_next = 1'b1;
        end
    end

    // Buffer registers; tready is its own flop mirroring skid emptiness
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            tready_reg     <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            tready_reg     <= ~skid_valid_next;
        end
    end

    assign s_axis_tready = tready_reg;
    assign m_axis_tvalid = main_valid_reg;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest} = main_reg;
    assign early_last    = early_reg;

endmodule

// File: tb/tb_axis_packetizer.sv
// Bench for axis_packetizer: directed packets checked against a queue-based
// packet model, plus literal tlast patterns per scenario.
`timescale 1ns/1ps
module tb_axis_packetizer;

    localparam int BW = 2;
    localparam int UW = 2;
    localparam int DW = 3;
    localparam int CW = 4;
    localparam int DWID = BW * 8;

    logic            aclk = 1'b0;
    logic            arstn = 1'b0;
    logic            s_valid = 1'b0, s_ready;
    logic [DWID-1:0] s_data = '0;
    logic [BW-1:0]   s_keep = '0;
    logic            s_last = 1'b0;
    logic [UW-1:0]   s_user = '0;
    logic [DW-1:0]   s_dest = '0;
    logic            m_valid, m_ready = 1'b1;
    logic [DWID-1:0] m_data;
    logic [BW-1:0]   m_keep;
    logic            m_last;
    logic [UW-1:0]   m_user;
    logic [DW-1:0]   m_dest;
    logic [CW-1:0]   pb = '0;
    logic            early_last;

    axis_packetizer #(.BUS_WIDTH(BW), .USER_WIDTH(UW), .DEST_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .aclk(aclk), .arstn(arstn),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
        .s_axis_tkeep(s_keep), .s_axis_tlast(s_last), .s_axis_tuser(s_user), .s_axis_tdest(s_dest),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
        .m_axis_tkeep(m_keep), .m_axis_tlast(m_last), .m_axis_tuser(m_user), .m_axis_tdest(m_dest),
        .packet_beats(pb), .early_last(early_last)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DWID-1:0] data;
        logic [BW-1:0]   keep;
        logic            last;
        logic [UW-1:0]   user;
        logic [DW-1:0]   dest;
    } beat_t;

    beat_t exp_q[$];
    int    acc_q[$];
    int    total = 0, bad = 0;
    int    pkt_pos = 0, pkt_size = 0;
    bit    exp_early = 0;
    int    cyc = 0;
    bit    prev_stall = 0;
    beat_t held;
    bit    check_lat = 1, rand_ready = 0;
    int    out_idx = 0, early_cnt = 0, last_cnt = 0;
    logic [31:0] last_mask = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always 1, or a fair coin during the random test
    always @(posedge aclk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor and model, sampled mid-cycle when every signal is settled
    always @(negedge aclk) begin
        beat_t cur, e, inb;
        int a;
        bit lst;
        cur = '{data: m_data, keep: m_keep, last: m_last, user: m_user, dest: m_dest};
        if (!arstn) begin
            chk("reset_outputs", {m_valid, cur, s_ready, early_last}, '0);
            exp_q.delete();
            acc_q.delete();
            pkt_pos = 0;
            exp_early = 0;
            prev_stall = 0;
        end else begin
            chk("early_last", early_last, exp_early);
            if (early_last) early_cnt++;
            exp_early = 0;
            if (prev_stall) chk("stall_stable", {m_valid, cur}, {1'b1, held});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", cur, '1);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("beat", cur, e);
                    if (check_lat) chk("latency", cyc - a, 1);
                    if (cur.last) begin
                        if (out_idx < 32) last_mask[out_idx] = 1'b1;
                        last_cnt++;
                    end
                    out_idx++;
                end
            end
            if (s_valid && s_ready) begin
                // Packet position rule: size is taken from the live input on a packet's first beat
                if (pkt_pos == 0) pkt_size = int'(pb);
                lst = s_last || (pkt_size != 0 && pkt_pos + 1 == pkt_size);
                exp_early = s_last && pkt_size != 0 && (pkt_pos + 1 < pkt_size);
                pkt_pos = lst ? 0 : pkt_pos + 1;
                inb = '{data: s_data, keep: s_keep, last: lst, user: s_user, dest: s_dest};
                exp_q.push_back(inb);
                acc_q.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready;
            held = cur;
            cyc++;
        end
    end

    task automatic send(input int d, input bit l, input bit gaps);
        bit hs;
        int n;
        if (gaps && $urandom_range(0, 1) == 1) begin
            s_valid = 1'b0;
            @(posedge aclk); #1;
        end
        s_valid = 1'b1;
        s_data  = DWID'(d);
        s_keep  = BW'(d);
        s_user  = UW'(d >> 2);
        s_dest  = DW'(d >> 4);
        s_last  = l;
        n = 0;
        do begin
            @(negedge aclk);
            hs = s_ready;
            @(posedge aclk); #1;
            n++;
        end while (!hs && n < 100);
        if (!hs) chk("send_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 300) begin
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic start_test();
        out_idx = 0;
        last_mask = '0;
        early_cnt = 0;
        last_cnt = 0;
    endtask

    task automatic report(input string name, input int beats, input logic [31:0] mask, input int early);
        chk({name, "_beats"}, out_idx, beats);
        chk({name, "_tlast_mask"}, last_mask, mask);
        chk({name, "_early"}, early_cnt, early);
        $display("%s: beats=%0d tlast_mask=%0h early=%0d", name, out_idx, last_mask, early_cnt);
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1 arstn = 1'b1;
        @(posedge aclk); #1;

        // Fixed size 4, contiguous 0..11
        pb = 4'd4; start_test();
        for (int i = 0; i < 12; i++) send(i, 1'b0, 1'b0);
        drain(); report("size4", 12, 32'h888, 0);

        // Size 8 cut short by input tlast on beat 3, then a full 8-beat packet
        pb = 4'd8; start_test();
        for (int i = 0; i < 3; i++) send(100 + i, i == 2, 1'b0);
        for (int i = 0; i < 8; i++) send(200 + i, 1'b0, 1'b0);
        drain(); report("early", 11, 32'h404, 1);

        // Pass-through: tlast only from the input on beats 5 and 9
        pb = 4'd0; start_test();
        for (int i = 1; i <= 9; i++) send(300 + i, (i == 5) || (i == 9), 1'b0);
        drain(); report("passthru", 9, 32'h110, 0);

        // Size changed 4 -> 2 mid-packet: current packet keeps 4
        pb = 4'd4; start_test();
        send(400, 1'b0, 1'b0); send(401, 1'b0, 1'b0);
        pb = 4'd2;
        for (int i = 2; i < 8; i++) send(400 + i, 1'b0, 1'b0);
        drain(); report("resize", 8, 32'hA8, 0);

        // Size 1: every beat is last
        pb = 4'd1; start_test();
        for (int i = 0; i < 5; i++) send(500 + i, 1'b0, 1'b0);
        drain(); report("size1", 5, 32'h1F, 0);

        // Maximum size 15 ends at count 14, then a short packet
        pb = 4'd15; start_test();
        for (int i = 0; i < 15; i++) send(600 + i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(700 + i, i == 2, 1'b0);
        drain(); report("maxsize", 18, 32'h24000, 1);

        // Random backpressure and gaps, 1000 beats
        pb = 4'd4; start_test(); check_lat = 0; rand_ready = 1;
        for (int i = 0; i < 1000; i++) send(i, 1'b0, 1'b1);
        rand_ready = 0;
        drain();
        chk("random_beats", out_idx, 1000);
        chk("random_tlast_count", last_cnt, 250);
        chk("random_early", early_cnt, 0);
        $display("random: beats=%0d tlast=%0d", out_idx, last_cnt);
        check_lat = 1;

        // Reset mid-packet, then a fresh 4-beat packet
        pb = 4'd4; start_test();
        send(800, 1'b0, 1'b0); send(801, 1'b0, 1'b0);
        arstn = 1'b0;
        #1 chk("async_reset_valid", {m_valid, s_ready}, 2'b00);
        repeat (3) @(posedge aclk);
        #1 arstn = 1'b1;
        @(negedge aclk);
        chk("tready_before_edge", s_ready, 1'b0);
        @(negedge aclk);
        chk("tready_after_edge", s_ready, 1'b1);
        @(posedge aclk); #1;
        start_test();
        for (int i = 0; i < 4; i++) send(900 + i, 1'b0, 1'b0);
        drain(); report("post_reset", 4, 32'h8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 Parameter BUS_WIDTH, default 1, tdata width in bytes; tkeep width is BUS_WIDTH bits.
REQ-002 Parameter USER_WIDTH, default 1, tuser width in bits.
REQ-003 Parameter DEST_WIDTH, default 1, tdest width in bits.
REQ-004 Parameter COUNT_WIDTH, default 16, width of packet_beats and the beat counter.
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 arstn  in  1  asynchronous active-low reset.
REQ-007 s_axis_tvalid/tready/tdata/tkeep/tlast/tuser/tdest  in/out/in/in/in/in/in  1/1/BUS_WIDTH*8/BUS_WIDTH/1/USER_WIDTH/DEST_WIDTH  upstream AXIS slave, fed by the axis_fifo master port.
REQ-008 m_axis_tvalid/tready/tdata/tkeep/tlast/tuser/tdest  out/in/out/out/out/out/out  same widths  downstream AXIS master.
REQ-009 packet_beats  in  COUNT_WIDTH  beats per packet; 0 means pass-through, so tlast comes only from the input stream.
REQ-010 early_last  out  1  one-cycle pulse when input tlast ends a packet short of packet_beats.

Function
REQ-011 The block SHALL forward every accepted beat unchanged in order, except m_axis_tlast, at one beat per cycle sustained when m_axis_tready=1.
REQ-012 The output SHALL be fully registered through a 2-entry skid buffer (main plus skid register).
  - m_axis_* and s_axis_tready SHALL be flop outputs.
  - Latency from s_axis accept to m_axis_tvalid SHALL be 1 cycle.
REQ-013 s_axis_tready SHALL be 1 when the skid register is empty and 0 when it holds a beat.
  - The skid register fills only when the main register is valid and m_axis_tready=0 while an input beat is accepted.
REQ-014 Once asserted, m_axis_tvalid SHALL hold and m_axis_* SHALL stay stable until m_axis_tready=1.
REQ-015 FSM states SHALL be IDLE (no beat of the current packet accepted) and ACTIVE (at least one beat accepted).
  - IDLE->ACTIVE on acceptance of a non-last beat.
  - ACTIVE->IDLE on acceptance of a last beat.
  - A last beat accepted in IDLE stays in IDLE.
REQ-016 On the first beat accepted in IDLE, the block SHALL latch packet_beats into size_reg; changes to packet_beats during ACTIVE SHALL be ignored.
REQ-017 The beat counter SHALL be COUNT_WIDTH bits.
  - Cleared in IDLE.
  - Incremented on each accepted beat.
  - Cleared on acceptance of a last beat.
REQ-018 Output tlast SHALL be (size != 0 and counter == size-1) OR s_axis_tlast, evaluated on the accepted beat. size is packet_beats on the first beat and size_reg thereafter.
REQ-019 The block SHALL pulse early_last for exactly one cycle, in the cycle after acceptance, when s_axis_tlast=1, size != 0 and counter < size-1.
REQ-020 packet_beats=1 SHALL make every beat a last beat.
REQ-021 The counter SHALL never wrap: a maximum packet_beats (2^COUNT_WIDTH-1) SHALL terminate at count 2^COUNT_WIDTH-2.
REQ-022 Simultaneous input accept and output drain SHALL neither lose nor duplicate a beat in any buffer occupancy.

Reset
REQ-023 While arstn=0, the following SHALL be 0: m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest, s_axis_tready, early_last, counter and size_reg. The FSM SHALL be in IDLE.
REQ-024 s_axis_tready SHALL assert on the first rising aclk after arstn deasserts.
REQ-025 Reset asserted mid-packet SHALL discard buffered beats and the partial count; the first beat after reset starts a new packet.

Verification
REQ-026 packet_beats=4, 12 contiguous beats with data 0..11, m_axis_tready=1 -> tlast on data 3, 7 and 11; one beat per cycle; 1-cycle latency.
REQ-027 packet_beats=8, input tlast on the 3rd beat -> output tlast on beat 3; early_last pulses once; the next packet counts 8 beats from zero.
REQ-028 packet_beats=0, input tlast on beats 5 and 9 -> output tlast is identical to input tlast; early_last never pulses.
REQ-029 packet_beats=4, random m_axis_tready at 50% and random s_axis_tvalid, 1000 beats -> output data sequence equals input sequence; no beat lost or duplicated; m_axis_* stable while stalled; tlast every 4th beat.
REQ-030 packet_beats changed from 4 to 2 after the 2nd beat of a packet -> that packet ends at beat 4; the following packets are 2 beats long.
REQ-031 arstn pulsed low after 2 beats of a 4-beat packet -> outputs 0 during reset; the next 4 beats form one packet with tlast on the 4th beat.
